// File: rtl/mul_round_n_if.sv
// Stream bundle for mul_round_n: the input sample with its per-channel
// coefficients on one side, the scaled results and overflow flags on the other.
interface mul_round_n_if #(
    parameter int DIN_W  = 12,
    parameter int COEF_W = 12,
    parameter int DOUT_W = 16,
    parameter int NCH    = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DIN_W-1:0] din;
    logic [NCH*COEF_W-1:0]   coef;
    logic                    out_valid;
    logic                    out_ready;
    logic [NCH*DOUT_W-1:0]   dout;
    logic [NCH-1:0]          sat_evt;

    modport master (
        output in_valid, din, coef, out_ready,
        input  in_ready, out_valid, dout, sat_evt
    );

    modport slave (
        input  in_valid, din, coef, out_ready,
        output in_ready, out_valid, dout, sat_evt
    );
endinterface

// File: rtl/mul_round_n.sv
// N-channel signed multiplier: one shared sample times NCH coefficients,
// each product scaled by SHIFT with optional round-half-away-from-zero and
// saturation. Three stages (capture, multiply, scale) advance in lockstep.

// One channel: coefficient capture, full-precision product, scale/round/clamp.
module mul_round_n_lane #(
    parameter int DIN_W  = 12,
    parameter int COEF_W = 12,
    parameter int DOUT_W = 16,
    parameter int SHIFT  = 8,
    parameter int RND    = 1,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     out_fire,
    input  logic                     sat_clr,
    input  logic signed [DIN_W-1:0]  din_s1,
    input  logic signed [COEF_W-1:0] coef_in,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     sat_evt,
    output logic                     sat_sticky
);
    localparam int PW = DIN_W + COEF_W;
    // One spare bit so the rounding increment can never wrap.
    localparam int RW = PW - SHIFT + 1;

    logic signed [COEF_W-1:0] coef_q, coef_d;
    logic signed [PW-1:0]     prod_q, prod_d;
    logic signed [DOUT_W-1:0] dout_q, dout_d;
    logic                     evt_q, evt_d;
    logic                     sticky_q, sticky_d;

    logic signed [PW-1:0]     din_ext, coef_ext;
    logic signed [RW-1:0]     trunc, rsum;
    logic                     rnd_inc;
    logic signed [DOUT_W-1:0] res;
    logic                     ovf;

    assign din_ext  = {{COEF_W{din_s1[DIN_W-1]}}, din_s1};
    assign coef_ext = {{DIN_W{coef_q[COEF_W-1]}}, coef_q};

    // Arithmetic shift, sign bit duplicated into the spare MSB.
    assign trunc = {prod_q[PW-1], prod_q[PW-1:SHIFT]};

    // Guard bit set rounds up, except an exact negative tie which floor already
    // moved away from zero.
    generate
        if (RND != 0 && SHIFT > 1) begin : g_rnd
            assign rnd_inc = prod_q[SHIFT-1] & (~prod_q[PW-1] | (|prod_q[SHIFT-2:0]));
        end else if (RND != 0 && SHIFT == 1) begin : g_rnd1
            assign rnd_inc = prod_q[0] & ~prod_q[PW-1];
        end else begin : g_nornd
            assign rnd_inc = 1'b0;
        end
    endgenerate

    assign rsum = trunc + {{(RW-1){1'b0}}, rnd_inc};

    // Overflow exists only when the rounded value is wider than the output.
    generate
        if (RW > DOUT_W) begin : g_sat
            logic hi, lo;
            assign hi  = ~rsum[RW-1] &  (|rsum[RW-2:DOUT_W-1]);
            assign lo  =  rsum[RW-1] & ~(&rsum[RW-2:DOUT_W-1]);
            assign ovf = hi | lo;
            assign res = (SAT != 0 && hi) ? {1'b0, {(DOUT_W-1){1'b1}}} :
                         (SAT != 0 && lo) ? {1'b1, {(DOUT_W-1){1'b0}}} :
                         rsum[DOUT_W-1:0];
        end else begin : g_ext
            assign ovf = 1'b0;
            assign res = DOUT_W'(rsum);
        end
    endgenerate

    // Stage data moves only with the shared enable; sticky set beats clear.
    always_comb begin
        coef_d = coef_q;
        prod_d = prod_q;
        dout_d = dout_q;
        evt_d  = evt_q;
        if (en) begin
            coef_d = coef_in;
            prod_d = din_ext * coef_ext;
            dout_d = res;
            evt_d  = ovf;
        end
        sticky_d = (sticky_q & ~sat_clr) | (out_fire & evt_q);
    end

    // Channel state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q   <= '0;
            prod_q   <= '0;
            dout_q   <= '0;
            evt_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            coef_q   <= coef_d;
            prod_q   <= prod_d;
            dout_q   <= dout_d;
            evt_q    <= evt_d;
            sticky_q <= sticky_d;
        end
    end

    assign dout       = dout_q;
    assign sat_evt    = evt_q;
    assign sat_sticky = sticky_q;
endmodule

// Top: shared valid pipeline and sample capture, one lane per channel.
module mul_round_n #(
    parameter int DIN_W  = 12,
    parameter int COEF_W = 12,
    parameter int DOUT_W = 16,
    parameter int NCH    = 2,
    parameter int SHIFT  = 8,
    parameter int RND    = 1,
    parameter int SAT    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_round_n_if.slave   bus,
    input  logic           sat_clr,
    output logic [NCH-1:0] sat_sticky
);
    localparam int STAGES = 3;

    logic [STAGES:1]            vld_pipe_q, vld_pipe_d;
    logic [STAGES:0]            vld_pipe;
    logic signed [DIN_W-1:0]    din_q, din_d;
    logic                       en, out_fire;
    logic [NCH-1:0][DOUT_W-1:0] dout_w;
    logic [NCH-1:0]             evt_w, sticky_w;

    assign vld_pipe = {vld_pipe_q, bus.in_valid};
    // Whole pipe stalls only when a held output is not being taken.
    assign en       = bus.out_ready | ~vld_pipe_q[STAGES];
    assign out_fire = vld_pipe_q[STAGES] & bus.out_ready;

    // Valids shift and the sample is captured together on enable.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        din_d      = din_q;
        if (en) begin
            vld_pipe_d = vld_pipe[STAGES-1:0];
            din_d      = bus.din;
        end
    end

    // Valid pipe and sample register; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            din_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            din_q      <= din_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        mul_round_n_lane #(
            .DIN_W (DIN_W),
            .COEF_W(COEF_W),
            .DOUT_W(DOUT_W),
            .SHIFT (SHIFT),
            .RND   (RND),
            .SAT   (SAT)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .out_fire  (out_fire),
            .sat_clr   (sat_clr),
            .din_s1    (din_q),
            .coef_in   (bus.coef[k*COEF_W +: COEF_W]),
            .dout      (dout_w[k]),
            .sat_evt   (evt_w[k]),
            .sat_sticky(sticky_w[k])
        );
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe_q[STAGES];
    assign bus.dout      = dout_w;
    assign bus.sat_evt   = evt_w;
    assign sat_sticky    = sticky_w;
endmodule

// File: tb/tb_mul_round_n.sv
// Bench for mul_round_n: seven configurations share one stimulus stream; every
// output transfer is compared against an arithmetic reference model.
module tb_mul_round_n;
    localparam int ND = 7;
    localparam int SH [ND] = '{8, 8, 6, 6, 12, 0, 8};
    localparam int RN [ND] = '{1, 0, 1, 1, 0, 1, 1};
    localparam int SA [ND] = '{1, 1, 1, 0, 1, 0, 1};
    localparam int NC [ND] = '{2, 2, 2, 2, 2, 2, 4};

    typedef struct {
        logic [11:0] d;
        logic [47:0] c;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv, ordy, clr;
    logic [11:0] din_r;
    logic [47:0] c_r;

    logic [63:0] dout_a [ND];
    logic [3:0]  evt_a  [ND];
    logic [3:0]  stk_a  [ND];
    logic        ov_a   [ND];
    logic        ir_a   [ND];

    int          checks = 0;
    int          failures = 0;
    smp_t        q [$];
    logic [3:0]  stk_m  [ND];
    logic [63:0] dout_p [ND];
    logic [3:0]  evt_p  [ND];
    logic [63:0] snap   [ND];
    logic [3:0]  esnap  [ND];
    logic        stall_prev = 1'b0;
    logic        ov_seen = 1'b0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < ND; i++) begin : g_dut
        localparam int N = NC[i];
        mul_round_n_if #(.DIN_W(12), .COEF_W(12), .DOUT_W(16), .NCH(N)) bif ();
        logic [N-1:0] stk;
        assign bif.in_valid  = iv;
        assign bif.din       = din_r;
        assign bif.coef      = c_r[N*12-1:0];
        assign bif.out_ready = ordy;
        assign dout_a[i]     = 64'(bif.dout);
        assign evt_a[i]      = 4'(bif.sat_evt);
        assign stk_a[i]      = 4'(stk);
        assign ov_a[i]       = bif.out_valid;
        assign ir_a[i]       = bif.in_ready;
        mul_round_n #(
            .DIN_W(12), .COEF_W(12), .DOUT_W(16), .NCH(N),
            .SHIFT(SH[i]), .RND(RN[i]), .SAT(SA[i])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .bus       (bif),
            .sat_clr   (clr),
            .sat_sticky(stk)
        );
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact product, scaled with integer arithmetic, then clamped or wrapped.
    function automatic void ref_calc(input longint p, input int sh, input int rnd,
                                     input int sat, output longint v, output bit e);
        longint t, half, mx, mn, w;
        if (sh == 0)       t = p;
        else if (rnd == 0) t = p >>> sh;
        else begin
            half = 64'sd1 <<< (sh - 1);
            if (p >= 0) t = (p + half) >>> sh;
            else        t = -((-p + half) >>> sh);
        end
        mx = 32767;
        mn = -32768;
        e = 1'b0;
        v = t;
        if (t > mx || t < mn) begin
            e = 1'b1;
            if (sat != 0) v = (t > mx) ? mx : mn;
            else begin
                w = t & 64'hFFFF;
                if (w > mx) w = w - 65536;
                v = w;
            end
        end
    endfunction

    function automatic longint sx(input int i, input int k);
        logic signed [15:0] v;
        v = snap[i][k*16 +: 16];
        return longint'(v);
    endfunction

    function automatic logic [47:0] rep4(input int v);
        return {4{12'(v)}};
    endfunction

    // One clock: check sticky, drive inputs, check handshake/hold/scoreboard, clock.
    task automatic step(input logic v, input logic [11:0] d, input logic [47:0] c,
                        input logic o, input logic cl, output logic fired);
        smp_t               s;
        logic [3:0]         nxt [ND];
        logic signed [11:0] dd, ck;
        logic signed [15:0] od;
        longint             ev;
        bit                 ee;
        logic               ofire, exp_rdy;
        for (int i = 0; i < ND; i++)
            chk($sformatf("sat_sticky[%0d]", i), longint'(stk_a[i]), longint'(stk_m[i]));
        iv = v; din_r = d; c_r = c; ordy = o; clr = cl;
        #1;
        fired   = v & ir_a[0];
        ofire   = ov_a[0] & o;
        ov_seen = ov_a[0];
        for (int i = 0; i < ND; i++) begin
            snap[i]  = dout_a[i];
            esnap[i] = evt_a[i];
            exp_rdy  = o | ~ov_a[i];
            chk($sformatf("in_ready[%0d]", i), longint'(ir_a[i]), longint'(exp_rdy));
            if (stall_prev) begin
                chk($sformatf("hold_valid[%0d]", i), longint'(ov_a[i]), 1);
                chk($sformatf("hold_dout[%0d]", i), longint'(dout_a[i]), longint'(dout_p[i]));
                chk($sformatf("hold_evt[%0d]", i), longint'(evt_a[i]), longint'(evt_p[i]));
            end
            nxt[i] = cl ? 4'h0 : stk_m[i];
        end
        if (ofire) begin
            if (q.size() == 0) chk("spurious_out", longint'(ov_a[0]), 0);
            else begin
                s  = q.pop_front();
                dd = s.d;
                for (int i = 0; i < ND; i++) begin
                    for (int k = 0; k < NC[i]; k++) begin
                        ck = s.c[k*12 +: 12];
                        ref_calc(longint'(dd) * longint'(ck), SH[i], RN[i], SA[i], ev, ee);
                        od = dout_a[i][k*16 +: 16];
                        chk($sformatf("dout[%0d][%0d]", i, k), longint'(od), ev);
                        chk($sformatf("sat_evt[%0d][%0d]", i, k), longint'(evt_a[i][k]), longint'(ee));
                        if (ee) nxt[i][k] = 1'b1;
                    end
                end
            end
        end
        if (fired) q.push_back('{d, c});
        stall_prev = ov_a[0] & ~o;
        for (int i = 0; i < ND; i++) begin
            dout_p[i] = dout_a[i];
            evt_p[i]  = evt_a[i];
        end
        @(posedge clk);
        for (int i = 0; i < ND; i++) stk_m[i] = nxt[i];
        @(negedge clk);
    endtask

    // Single sample with free-flowing output; returns cycles until out_valid.
    task automatic one_shot(input logic [11:0] d, input logic [47:0] c, output int lat);
        logic f;
        lat = -1;
        step(1'b1, d, c, 1'b1, 1'b0, f);
        for (int j = 0; j < 8; j++) begin
            step(1'b0, d, c, 1'b1, 1'b0, f);
            if (ov_seen) begin
                lat = j + 1;
                break;
            end
        end
        if (lat < 0) chk("one_shot_timeout", longint'(ov_seen), 1);
    endtask

    initial begin
        logic f;
        int   lat, sent;
        logic [3:0] pat;
        for (int i = 0; i < ND; i++) stk_m[i] = 4'h0;
        rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; clr = 1'b0; din_r = '0; c_r = '0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("rst_out_valid[%0d]", i), longint'(ov_a[i]), 0);
            chk($sformatf("rst_dout[%0d]", i), longint'(dout_a[i]), 0);
            chk($sformatf("rst_sat_evt[%0d]", i), longint'(evt_a[i]), 0);
            chk($sformatf("rst_sticky[%0d]", i), longint'(stk_a[i]), 0);
            chk($sformatf("rst_in_ready[%0d]", i), longint'(ir_a[i]), 1);
        end
        rst_n = 1'b1;

        // Rounding and latency with coefficient 128 and SHIFT 8
        one_shot(12'd3, rep4(128), lat);
        chk("latency", lat, 3);
        chk("din3_rnd", sx(0, 0), 2);
        chk("din3_rnd_ch1", sx(0, 1), 2);
        chk("din3_trunc", sx(1, 0), 1);
        one_shot(12'(-3), rep4(128), lat);
        chk("dinm3_rnd", sx(0, 0), -2);
        chk("dinm3_trunc", sx(1, 0), -2);
        one_shot(12'd1, rep4(128), lat);
        chk("din1_rnd", sx(0, 0), 1);
        chk("din1_trunc", sx(1, 0), 0);
        one_shot(12'(-1), rep4(128), lat);
        chk("dinm1_rnd", sx(0, 0), -1);
        chk("dinm1_trunc", sx(1, 0), -1);
        one_shot(12'd383, rep4(1), lat);
        chk("p383_rnd", sx(0, 0), 1);

        // Full-scale product: clamp vs wrap, sticky set and clear
        one_shot(12'h800, rep4(-2048), lat);
        chk("sat_dout", sx(2, 0), 32767);
        chk("sat_evt", longint'(esnap[2]), 3);
        chk("wrap_dout", sx(3, 0), 0);
        chk("wrap_evt", longint'(esnap[3]), 3);
        chk("sticky_set", longint'(stk_a[2]), 3);
        step(1'b0, 12'd0, '0, 1'b1, 1'b1, f);
        chk("sticky_clr", longint'(stk_a[2]), 0);

        // Four channels with mixed-sign small and unity-gain coefficients
        one_shot(12'd100, {12'd1, 12'hFFF, 12'd256, 12'hF00}, lat);
        chk("nch4_100_c0", sx(6, 0), -100);
        chk("nch4_100_c1", sx(6, 1), 100);
        chk("nch4_100_c2", sx(6, 2), 0);
        chk("nch4_100_c3", sx(6, 3), 0);
        one_shot(12'd128, {12'd1, 12'hFFF, 12'd256, 12'hF00}, lat);
        chk("nch4_128_c0", sx(6, 0), -128);
        chk("nch4_128_c1", sx(6, 1), 128);
        chk("nch4_128_c2", sx(6, 2), -1);
        chk("nch4_128_c3", sx(6, 3), 1);

        // Ramp under out_ready pattern 1,0,0,1
        pat  = 4'b1001;
        sent = 0;
        for (int i = 0; i < 80 && sent < 10; i++) begin
            step(1'b1, 12'(sent * 37 - 150), rep4(300 + sent), pat[i % 4], 1'b0, f);
            if (f) sent++;
        end
        chk("ramp_sent", sent, 10);
        for (int j = 0; j < 20 && q.size() > 0; j++) step(1'b0, 12'd0, '0, 1'b1, 1'b0, f);
        chk("ramp_drained", q.size(), 0);

        // Random traffic with random backpressure, extremes and sat_clr
        for (int i = 0; i < 400; i++) begin
            logic [11:0] d;
            logic [47:0] c;
            case ($urandom_range(0, 3))
                0:       d = 12'h800;
                1:       d = 12'h7FF;
                default: d = 12'($urandom);
            endcase
            c = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) c = rep4($urandom_range(0, 1) != 0 ? -2048 : 2047);
            step(1'($urandom_range(0, 3) != 0), d, c, 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 19) == 0), f);
        end
        for (int j = 0; j < 20 && q.size() > 0; j++) step(1'b0, 12'd0, '0, 1'b1, 1'b0, f);
        chk("random_drained", q.size(), 0);

        // Reset with three samples in flight and sticky set
        one_shot(12'h800, rep4(-2048), lat);
        for (int j = 0; j < 3; j++) step(1'b1, 12'(j * 50 + 7), rep4(100 + j), 1'b1, 1'b0, f);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("midrst_valid[%0d]", i), longint'(ov_a[i]), 0);
            chk($sformatf("midrst_dout[%0d]", i), longint'(dout_a[i]), 0);
            chk($sformatf("midrst_sticky[%0d]", i), longint'(stk_a[i]), 0);
            stk_m[i] = 4'h0;
        end
        q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) step(1'b0, 12'd0, '0, 1'b1, 1'b0, f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
